spk_event_packer: RTL and testbench
===================================

// Module: spk_event_packer
// PURPOSE
//  Downstream of the threshold/peak-detect stage. Turns each per-channel peak
//  flag into a timestamped 64-bit event word: frame number, channel, amplitude.
//  Applies a per-channel refractory window to suppress duplicate peaks.
//  Buffers accepted events in a FIFO and drains them to the host link over valid/ready.
// PARAMETERS
//  NUM_CH        32   channels per frame; ch_in ranges 0..NUM_CH-1
//  REFRAC_FRAMES 8    minimum frame gap between two accepted events on one channel
//  DEPTH         256  event FIFO depth; power of two
//  AW            8    log2(DEPTH)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  en         in   1   1 = accept peaks; 0 = drop all peaks; frame counting continues
//  clr_stats  in   1   one-cycle pulse; clears drop_cnt and overflow
//  valid_in   in   1   sample strobe from the peak detector
//  eof_in     in   1   last channel of the current frame; qualified by valid_in
//  ch_in      in   8   channel number of the current sample
//  is_peak_in in   1   peak flag; qualified by valid_in
//  min_in     in   32  signed running minimum of ch_in, used as the event amplitude
//  spk_valid  out  1   spk_data holds an event
//  spk_ready  in   1   host consumes an event when spk_valid && spk_ready
//  spk_data   out  64  {frame_no[31:0], ch[7:0], amp[23:0]}
//  fifo_cnt   out  AW+1 number of stored events
//  drop_cnt   out  16  events lost because the FIFO was full; saturates at 16'hFFFF
//  overflow   out  1   sticky; set on the first drop
// BEHAVIOUR
//  - Reset (async, active-high): frame_no=0, all armed[]=0, FIFO empty, spk_valid=0,
//    spk_data=0, fifo_cnt=0, drop_cnt=0, overflow=0, input stage cleared.
//  - frame_no: 32-bit. Increments on the edge after a beat with valid_in && eof_in.
//    Every sample of a frame, including the eof sample, is stamped with the pre-increment value.
//    Wraps 0xFFFFFFFF -> 0.
//  - Candidate event: valid_in && is_peak_in && en && ch_in < NUM_CH. ch_in >= NUM_CH is ignored.
//  - Refractory: per channel, keep last[ch] (32 b) and armed[ch].
//    A candidate is accepted iff !armed[ch] || (frame_no - last[ch]) mod 2^32 >= REFRAC_FRAMES.
//    On acceptance: last[ch] <= frame_no and armed[ch] <= 1.
//    A rejected candidate leaves last[ch] and armed[ch] unchanged.
//    The refractory update happens even if the FIFO push is dropped.
//  - Amplitude: amp = min_in saturated to signed 24 bit.
//    min_in > 0x7FFFFF gives 0x7FFFFF; min_in < -0x800000 gives 0x800000.
//  - Pipeline, stage 1: on the edge after the candidate beat, register the
//    accept decision, frame_no, ch and amp.
//  - Pipeline, stage 2: on the next edge, write the FIFO.
//    If the FIFO was empty, spk_valid rises on that same edge.
//    Latency from candidate beat to spk_valid is 2 clocks.
//  - FIFO: first-word fall-through. spk_data is stable while spk_valid && !spk_ready.
//    A push is allowed when not full, or when full and a pop happens in the same cycle.
//    Otherwise the event is dropped: drop_cnt increments (saturating) and overflow is set.
//    Simultaneous push and pop leaves fifo_cnt unchanged.
//    Pop on an empty FIFO is ignored.
//  - clr_stats clears drop_cnt and overflow only.
//    If a drop occurs in the same cycle as clr_stats, the drop wins: drop_cnt=1, overflow=1.
//  - en falling mid-stream: events already in stage 1/2 still complete; new candidates are dropped.
//    Refractory state is not updated for candidates that arrive while en=0.
//  - Back-to-back candidates on the same channel in consecutive cycles: the second one sees
//    the updated armed[]/last[] (write-through from stage 1), so it is rejected while inside the window.
// STRUCTURE
//  - Shared package xike_pkg: EVT_W=64, FRAME_W=32, AMP_W=24, typedef spk_evt_t
//    {frame_no, ch, amp}, and the sat24 function.
//  - Sub-module spk_evt_fifo: synchronous FWFT FIFO, parameters DEPTH/AW,
//    distributed RAM with registered pointers.
//  - last[] and armed[] are distributed RAM / register arrays indexed by ch_in.
// TESTING
//  1. Reset then one peak on ch 5 in frame 0, min_in=-1200
//     -> spk_valid 2 clocks later; spk_data={32'd0, 8'd5, 24'hFFFB50}.
//  2. ch 3 peaks in frames 10, 14 and 18 (REFRAC_FRAMES=8)
//     -> events for frames 10 and 18 only; frame 14 is rejected.
//  3. spk_ready=0 with 257 accepted peaks (DEPTH=256)
//     -> fifo_cnt=256, drop_cnt=1, overflow=1.
//     Then pulse clr_stats -> drop_cnt=0, overflow=0, fifo_cnt still 256.
//  4. FIFO full and spk_ready=1 in the same cycle as a new peak
//     -> no drop; fifo_cnt stays 256; the order of the host-side stream is preserved.
//  5. min_in=-32'sd20000000 -> amp=24'h800000. min_in=+32'sd9000000 -> amp=24'h7FFFFF.
//  6. frame_no preloaded to 0xFFFFFFFC (force); ch 2 peaks at 0xFFFFFFFC and at frame 4 after the wrap
//     -> both accepted (gap 8). rst asserted while events are pending -> everything cleared immediately.

Source files
------------

// File: rtl/xike_pkg.sv
// Shared types and helpers for the spike event path.
package xike_pkg;

  localparam int EVT_W   = 64;
  localparam int FRAME_W = 32;
  localparam int AMP_W   = 24;
  localparam int CH_W    = 8;

  localparam logic signed [31:0] AMP_MAX = 32'sh007F_FFFF;
  localparam logic signed [31:0] AMP_MIN = 32'shFF80_0000;

  typedef struct packed {
    logic [FRAME_W-1:0] frame_no;
    logic [CH_W-1:0]    ch;
    logic [AMP_W-1:0]   amp;
  } spk_evt_t;

  // Clamp a signed 32-bit value into the signed 24-bit amplitude field.
  function automatic logic [AMP_W-1:0] sat24(input logic signed [31:0] v);
    logic [AMP_W-1:0] r;
    if (v > AMP_MAX) begin
      r = 24'h7F_FFFF;
    end else if (v < AMP_MIN) begin
      r = 24'h80_0000;
    end else begin
      r = v[AMP_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/spk_evt_fifo.sv
// First-word fall-through event FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is reported as a drop.
module spk_evt_fifo
  import xike_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [EVT_W-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [EVT_W-1:0] data_o,
  output logic [AW:0]      cnt_o,
  output logic             drop_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             empty, full, pop, wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = pop_ready_i && !empty;
  // When full, the slot being popped is the one being written, so the
  // read (combinational, old contents) and write (at the edge) do not collide.
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && !wr_en;

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spk_event_packer.sv
// Turns per-channel peak flags into timestamped event words, suppresses
// repeats inside a per-channel refractory window, and queues them for the host.
module spk_event_packer
  import xike_pkg::*;
#(
  parameter int NUM_CH        = 32,
  parameter int REFRAC_FRAMES = 8,
  parameter int DEPTH         = 256,
  parameter int AW            = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_stats,
  input  logic                valid_in,
  input  logic                eof_in,
  input  logic [7:0]          ch_in,
  input  logic                is_peak_in,
  input  logic signed [31:0]  min_in,
  output logic                spk_valid,
  input  logic                spk_ready,
  output logic [EVT_W-1:0]    spk_data,
  output logic [AW:0]         fifo_cnt,
  output logic [15:0]         drop_cnt,
  output logic                overflow
);

  localparam int CI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [FRAME_W-1:0] frame_no_q, frame_no_d;
  logic [FRAME_W-1:0] last_q [NUM_CH];
  logic [NUM_CH-1:0]  armed_q;
  logic [CI_W-1:0]    ch_idx;
  logic [FRAME_W-1:0] gap;
  logic               ch_ok, cand, accept;
  logic               s1_vld_q;
  spk_evt_t           s1_evt_q, s1_evt_d;
  logic               fifo_drop;
  logic [15:0]        drop_cnt_q;
  logic               overflow_q;

  assign frame_no_d = (valid_in && eof_in) ? frame_no_q + 1'b1 : frame_no_q;

  assign ch_ok  = ({24'b0, ch_in} < 32'(NUM_CH));
  assign ch_idx = ch_in[CI_W-1:0];
  assign cand   = valid_in && is_peak_in && en && ch_ok;
  // Modular gap keeps the window correct across frame counter wrap.
  assign gap    = frame_no_q - last_q[ch_idx];
  assign accept = cand && (!armed_q[ch_idx] || (gap >= 32'(REFRAC_FRAMES)));

  always_comb begin
    s1_evt_d.frame_no = frame_no_q;
    s1_evt_d.ch       = ch_in;
    s1_evt_d.amp      = sat24(min_in);
  end

  // Frame counter; eof sample is stamped with the pre-increment value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_no_q <= '0;
    else     frame_no_q <= frame_no_d;
  end

  // Armed flags; updated on acceptance so a next-cycle candidate already sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= '0;
    end else if (accept) begin
      armed_q[ch_idx] <= 1'b1;
    end
  end

  // Last accepted frame per channel; only meaningful while armed.
  always_ff @(posedge clk) begin
    if (accept) begin
      last_q[ch_idx] <= frame_no_q;
    end
  end

  // Stage 1: registered accept decision and event word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_evt_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_evt_q <= s1_evt_d;
    end
  end

  // Stage 2 is the FIFO write itself.
  spk_evt_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s1_vld_q),
    .push_data_i (s1_evt_q),
    .pop_ready_i (spk_ready),
    .valid_o     (spk_valid),
    .data_o      (spk_data),
    .cnt_o       (fifo_cnt),
    .drop_o      (fifo_drop)
  );

  // Drop statistics; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
      if (clr_stats)                  drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_stats) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spk_event_packer.sv
// Scoreboard bench for spk_event_packer: stimulus queues expected events,
// a negedge monitor pops and compares on every host handshake.
module tb_spk_event_packer;

  logic        clk, rst, en, clr_stats, valid_in, eof_in, is_peak_in, spk_ready;
  logic [7:0]  ch_in;
  logic signed [31:0] min_in;
  logic        spk_valid, overflow;
  logic [63:0] spk_data;
  logic [8:0]  fifo_cnt;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  logic [63:0] exp_q [$];
  logic [31:0] tb_frame = 32'd0;

  spk_event_packer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_stats  (clr_stats),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .ch_in      (ch_in),
    .is_peak_in (is_peak_in),
    .min_in     (min_in),
    .spk_valid  (spk_valid),
    .spk_ready  (spk_ready),
    .spk_data   (spk_data),
    .fifo_cnt   (fifo_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted host beat must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && spk_valid && spk_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_event: got %h expected none", spk_data);
      end else begin
        chk("event_data", spk_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic peak(input int ch, input int mn, input bit exp_push, input logic [23:0] exp_amp);
    valid_in   = 1'b1;
    is_peak_in = 1'b1;
    eof_in     = 1'b0;
    ch_in      = 8'(ch);
    min_in     = mn;
    if (exp_push) exp_q.push_back({tb_frame, 8'(ch), exp_amp});
    step();
    valid_in   = 1'b0;
    is_peak_in = 1'b0;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      valid_in = 1'b1;
      eof_in   = 1'b1;
      ch_in    = 8'd31;
      step();
      valid_in = 1'b0;
      eof_in   = 1'b0;
      tb_frame = tb_frame + 32'd1;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    spk_ready = 1'b1;
    step();
    step();
    budget = 600;
    while (spk_valid && budget > 0) begin
      step();
      budget--;
    end
    spk_ready = 1'b0;
    if (budget == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s_timeout: got fifo_cnt %0d expected 0", name, fifo_cnt);
    end
    chk({name, "_cnt"}, 64'(fifo_cnt), 64'd0);
    chk({name, "_sb"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr_stats = 1'b0; valid_in = 1'b0; eof_in = 1'b0;
    is_peak_in = 1'b0; spk_ready = 1'b0; ch_in = 8'd0; min_in = 32'sd0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_valid", 64'(spk_valid), 64'd0);
    chk("rst_data", spk_data, 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // 1: single event, 2-clock latency
    peak(5, -1200, 1, 24'hFFFB50);
    chk("lat1_valid", 64'(spk_valid), 64'd0);
    step();
    chk("lat2_valid", 64'(spk_valid), 64'd1);
    chk("lat2_data", spk_data, {32'd0, 8'd5, 24'hFFFB50});
    chk("lat2_cnt", 64'(fifo_cnt), 64'd1);
    drain("t1");

    // 2: refractory window on ch 3, enable gating, out-of-range channel
    advance(10);
    peak(3, 100, 1, 24'd100);
    advance(4);
    peak(3, 101, 0, 24'd0);
    advance(3);
    peak(3, 102, 0, 24'd0);
    advance(1);
    peak(3, 103, 1, 24'd103);
    peak(3, 104, 0, 24'd0);
    en = 1'b0;
    peak(7, 200, 0, 24'd0);
    en = 1'b1;
    peak(7, 201, 1, 24'd201);
    peak(40, 202, 0, 24'd0);
    peak(6, 300, 1, 24'd300);
    en = 1'b0;
    step();
    en = 1'b1;
    drain("t2");

    // 3: fill past depth with host stalled
    advance(8);
    for (int i = 0; i < 257; i++) begin
      if (i > 0 && (i % 32) == 0) advance(8);
      peak(i % 32, i, (i < 256), 24'(i));
    end
    step();
    step();
    chk("full_cnt", 64'(fifo_cnt), 64'd256);
    chk("full_drop", 64'(drop_cnt), 64'd1);
    chk("full_ovf", 64'(overflow), 64'd1);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_cnt", 64'(fifo_cnt), 64'd256);

    // Dropped event still armed ch 0, so a repeat is rejected (no new drop)
    peak(0, 999, 0, 24'd0);
    step();
    step();
    chk("drop_refrac", 64'(drop_cnt), 64'd0);

    // 4: push into full FIFO with a simultaneous pop
    peak(1, 77, 1, 24'd77);
    spk_ready = 1'b1;
    step();
    spk_ready = 1'b0;
    chk("pp_cnt", 64'(fifo_cnt), 64'd256);
    chk("pp_drop", 64'(drop_cnt), 64'd0);
    chk("pp_ovf", 64'(overflow), 64'd0);
    drain("t4");

    // 5: amplitude saturation and its boundaries
    spk_ready = 1'b1;
    peak(8, -20000000, 1, 24'h800000);
    peak(9, 9000000, 1, 24'h7FFFFF);
    peak(10, -8388608, 1, 24'h800000);
    peak(11, 8388607, 1, 24'h7FFFFF);
    peak(12, 8388608, 1, 24'h7FFFFF);
    peak(13, -8388609, 1, 24'h800000);
    drain("t5");

    // 6: frame counter wrap
    force dut.frame_no_q = 32'hFFFF_FFFC;
    step();
    release dut.frame_no_q;
    tb_frame = 32'hFFFF_FFFC;
    peak(2, 11, 1, 24'd11);
    advance(7);
    peak(2, 12, 0, 24'd0);
    advance(1);
    chk("wrap_frame", 64'(tb_frame), 64'd4);
    peak(2, 13, 1, 24'd13);
    drain("t6");

    // Reset with events in flight
    spk_ready = 1'b0;
    peak(9, 21, 0, 24'd0);
    peak(10, 22, 0, 24'd0);
    chk("pre_rst_valid", 64'(spk_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(spk_valid), 64'd0);
    chk("arst_cnt", 64'(fifo_cnt), 64'd0);
    chk("arst_data", spk_data, 64'd0);
    step();
    rst = 1'b0;
    tb_frame = 32'd0;
    advance(4);
    peak(9, 23, 1, 24'd23);
    drain("t7");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
